// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// The state encoding is fixed at IDLE=0 and GRANT=1.
package fifo_wr_arbiter_pkg;

  localparam int N_DEFAULT         = 4;
  localparam int DW_DEFAULT        = 8;
  localparam int MAX_BURST_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arbState_e;

  // The beat counter must hold values 0..MAX_BURST, so it needs enough bits for MAX_BURST+1 states.
  function automatic int beatWidth(input int maxBurst);
    return $clog2(maxBurst + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
// The urgent_i lane exists only when ARB_URGENT_EN is defined.
interface fifo_wr_arbiter_if import fifo_wr_arbiter_pkg::*; #(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
);

  logic [N-1:0]    req_i;
  logic [N*DW-1:0] dinBus_i;
  logic            fifoFull_i;
`ifdef ARB_URGENT_EN
  logic [N-1:0]    urgent_i;
`endif
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    ack_o;
  logic            fifoWEn_o;
  logic [DW-1:0]   fifoDin_o;
  logic            busy_o;

  modport master (
`ifdef ARB_URGENT_EN
    output urgent_i,
`endif
    output req_i, dinBus_i, fifoFull_i,
    input  gnt_o, ack_o, fifoWEn_o, fifoDin_o, busy_o
  );

  modport slave (
`ifdef ARB_URGENT_EN
    input  urgent_i,
`endif
    input  req_i, dinBus_i, fifoFull_i,
    output gnt_o, ack_o, fifoWEn_o, fifoDin_o, busy_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first asserted request after last_i.
// The scan wraps around, so last_i itself has the lowest priority.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [$clog2(N)-1:0] pick_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    int idx;
    idx     = 0;
    pick_o  = '0;
    valid_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_i) + k) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        pick_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among N requesters, granting bursts of up to MAX_BURST words.
// When ARB_URGENT_EN is defined, urgent requests jump the round-robin queue in IDLE.
module fifo_wr_arbiter import fifo_wr_arbiter_pkg::*; #(
  parameter int N         = N_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = $clog2(N);
  localparam int BW = beatWidth(MAX_BURST);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(N - 1);

  arbState_e     state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gntIdx_q, gntIdx_d;
  logic [IW-1:0] last_q, last_d;
  logic [BW-1:0] beatCnt_q, beatCnt_d;

  logic [IW-1:0] rrPick;
  logic          rrValid;
  logic [IW-1:0] pick;
  logic          pickValid;
  logic          accept;

  rr_pick #(.N(N)) uPick (
    .req_i   (bus.req_i),
    .last_i  (last_q),
    .pick_o  (rrPick),
    .valid_o (rrValid)
  );

`ifdef ARB_URGENT_EN
  // Any urgent request is also a request, so the round-robin valid flag still covers it.
  always_comb begin
    pick      = rrPick;
    pickValid = rrValid;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_i[i] && bus.urgent_i[i]) pick = IW'(i);
    end
  end
`else
  assign pick      = rrPick;
  assign pickValid = rrValid;
`endif

  // The word in a reset cycle is dropped, so rst blocks acceptance combinationally.
  assign accept = (state_q == ST_GRANT) && bus.req_i[gntIdx_q] && !bus.fifoFull_i && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gntIdx_q  <= '0;
      last_q    <= LAST_INIT;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gntIdx_q  <= gntIdx_d;
      last_q    <= last_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gntIdx_d  = gntIdx_q;
    last_d    = last_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pickValid) begin
          state_d     = ST_GRANT;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          gntIdx_d    = pick;
          beatCnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (accept) beatCnt_d = beatCnt_q + 1'b1;
        // Release when the requester lets go or the final permitted beat is taken; a full FIFO simply stalls.
        if (!bus.req_i[gntIdx_q] || (accept && beatCnt_q == LAST_BEAT)) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          last_d    = gntIdx_q;
          beatCnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt_o     = gnt_q;
    bus.busy_o    = (state_q == ST_GRANT);
    bus.fifoWEn_o = accept;
    bus.ack_o     = gnt_q & {N{accept}};
    bus.fifoDin_o = (|gnt_q) ? bus.dinBus_i[int'(gntIdx_q) * DW +: DW] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (N=4, DW=8, MAX_BURST=4).
// The urgent-override step is built only when ARB_URGENT_EN is defined.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;
  logic [7:0] fifoQ[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(4), .DW(8)) bus ();

  fifo_wr_arbiter #(.N(4), .DW(8), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model of the FIFO input: record every word the arbiter writes.
  always @(negedge clk) begin
    if (bus.fifoWEn_o === 1'b1) fifoQ.push_back(bus.fifoDin_o);
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic full);
    bus.req_i      = req;
    bus.fifoFull_i = full;
  endtask

  task automatic setData(input int idx, input logic [7:0] val);
    bus.dinBus_i[idx*8 +: 8] = val;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int lens[3];
    int w;
    lens = '{4, 4, 2};
    rst = 1'b1;
    bus.dinBus_i = '0;
`ifdef ARB_URGENT_EN
    bus.urgent_i = '0;
`endif
    applyStimulus(4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) setData(i, 8'(8'h10 + i));

    // Reset state, then requests present while reset is still held.
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("reset busy", 32'(bus.busy_o), 32'h0);
    checkOutput("reset wEn", 32'(bus.fifoWEn_o), 32'h0);
    nextCycle();
    applyStimulus(4'b1111, 1'b0);
    #1;
    checkOutput("reset-held wEn", 32'(bus.fifoWEn_o), 32'h0);
    checkOutput("reset-held ack", 32'(bus.ack_o), 32'h0);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("post-reset idle gnt", 32'(bus.gnt_o), 32'h0);
    nextCycle();

    // Test 1: all four requesting, full round of 4-beat bursts with one idle gap each.
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) begin
        #1;
        checkOutput($sformatf("t1 gnt k%0d b%0d", k, b), 32'(bus.gnt_o), 32'(1 << k));
        checkOutput($sformatf("t1 ack k%0d b%0d", k, b), 32'(bus.ack_o), 32'(1 << k));
        checkOutput($sformatf("t1 din k%0d b%0d", k, b), 32'(bus.fifoDin_o), 32'(8'h10 + k));
        nextCycle();
      end
      if (k == 3) applyStimulus(4'b0000, 1'b0);
      #1;
      checkOutput($sformatf("t1 gap gnt k%0d", k), 32'(bus.gnt_o), 32'h0);
      checkOutput($sformatf("t1 gap busy k%0d", k), 32'(bus.busy_o), 32'h0);
      nextCycle();
    end

    // Test 2: single requester streams A0..A9 as bursts of 4, 4, 2.
    fifoQ.delete();
    applyStimulus(4'b0100, 1'b0);
    setData(2, 8'hA0);
    #1;
    checkOutput("t2 idle gnt", 32'(bus.gnt_o), 32'h0);
    nextCycle();
    w = 0;
    for (int n = 0; n < 3; n++) begin
      for (int b = 0; b < lens[n]; b++) begin
        setData(2, 8'(8'hA0 + w));
        #1;
        checkOutput($sformatf("t2 ack w%0d", w), 32'(bus.ack_o), 32'h4);
        checkOutput($sformatf("t2 din w%0d", w), 32'(bus.fifoDin_o), 32'(8'hA0 + w));
        nextCycle();
        w++;
      end
      if (n < 2) begin
        #1;
        checkOutput($sformatf("t2 gap gnt n%0d", n), 32'(bus.gnt_o), 32'h0);
        checkOutput($sformatf("t2 gap din n%0d", n), 32'(bus.fifoDin_o), 32'h0);
        nextCycle();
      end
    end
    applyStimulus(4'b0000, 1'b0);
    #1;
    checkOutput("t2 drop gnt held", 32'(bus.gnt_o), 32'h4);
    checkOutput("t2 drop ack", 32'(bus.ack_o), 32'h0);
    checkOutput("t2 drop wEn", 32'(bus.fifoWEn_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t2 released gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("t2 fifo count", 32'(fifoQ.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < fifoQ.size())
        checkOutput($sformatf("t2 fifo[%0d]", i), 32'(fifoQ[i]), 32'(8'hA0 + i));
    end

    // Test 3: fifo_full for 5 cycles mid-burst; burst still ends after 4 accepted words.
    applyStimulus(4'b0010, 1'b0);
    setData(1, 8'hB0);
    nextCycle();
    #1;
    checkOutput("t3 gnt", 32'(bus.gnt_o), 32'h2);
    checkOutput("t3 ack b0", 32'(bus.ack_o), 32'h2);
    nextCycle();
    setData(1, 8'hB1);
    #1;
    checkOutput("t3 ack b1", 32'(bus.ack_o), 32'h2);
    nextCycle();
    applyStimulus(4'b0010, 1'b1);
    for (int s = 0; s < 5; s++) begin
      #1;
      checkOutput($sformatf("t3 stall wEn s%0d", s), 32'(bus.fifoWEn_o), 32'h0);
      checkOutput($sformatf("t3 stall ack s%0d", s), 32'(bus.ack_o), 32'h0);
      checkOutput($sformatf("t3 stall gnt s%0d", s), 32'(bus.gnt_o), 32'h2);
      checkOutput($sformatf("t3 stall busy s%0d", s), 32'(bus.busy_o), 32'h1);
      nextCycle();
    end
    applyStimulus(4'b0010, 1'b0);
    setData(1, 8'hB2);
    #1;
    checkOutput("t3 ack b2", 32'(bus.ack_o), 32'h2);
    checkOutput("t3 din b2", 32'(bus.fifoDin_o), 32'hB2);
    nextCycle();
    setData(1, 8'hB3);
    #1;
    checkOutput("t3 ack b3", 32'(bus.ack_o), 32'h2);
    nextCycle();
    applyStimulus(4'b0000, 1'b0);
    #1;
    checkOutput("t3 released gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("t3 released busy", 32'(bus.busy_o), 32'h0);

    // Test 4: reset during beat 2; rotation restarts with requester 0.
    applyStimulus(4'b0100, 1'b0);
    setData(2, 8'hC0);
    nextCycle();
    #1;
    checkOutput("t4 gnt", 32'(bus.gnt_o), 32'h4);
    checkOutput("t4 ack b0", 32'(bus.ack_o), 32'h4);
    nextCycle();
    setData(2, 8'hC1);
    #1;
    checkOutput("t4 ack b1", 32'(bus.ack_o), 32'h4);
    nextCycle();
    setData(2, 8'hC2);
    rst = 1'b1;
    #1;
    checkOutput("t4 rst wEn", 32'(bus.fifoWEn_o), 32'h0);
    checkOutput("t4 rst ack", 32'(bus.ack_o), 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b0);
    #1;
    checkOutput("t4 after rst gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("t4 after rst busy", 32'(bus.busy_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t4 first gnt", 32'(bus.gnt_o), 32'h1);
    checkOutput("t4 first ack", 32'(bus.ack_o), 32'h1);

    // Test 5: requester 1 drops after one word while requester 3 waits.
    nextCycle();
    applyStimulus(4'b1010, 1'b0);
    #1;
    checkOutput("t5 r0 drop gnt", 32'(bus.gnt_o), 32'h1);
    checkOutput("t5 r0 drop ack", 32'(bus.ack_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t5 idle a gnt", 32'(bus.gnt_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t5 gnt r1", 32'(bus.gnt_o), 32'h2);
    checkOutput("t5 ack r1", 32'(bus.ack_o), 32'h2);
    nextCycle();
    applyStimulus(4'b1000, 1'b0);
    #1;
    checkOutput("t5 r1 drop gnt", 32'(bus.gnt_o), 32'h2);
    checkOutput("t5 r1 drop wEn", 32'(bus.fifoWEn_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t5 idle b gnt", 32'(bus.gnt_o), 32'h0);
    checkOutput("t5 idle b busy", 32'(bus.busy_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t5 gnt r3", 32'(bus.gnt_o), 32'h8);
    checkOutput("t5 ack r3", 32'(bus.ack_o), 32'h8);
    nextCycle();
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    #1;
    checkOutput("t5 final idle gnt", 32'(bus.gnt_o), 32'h0);

`ifdef ARB_URGENT_EN
    // Test 6: with last=0, urgent requester 2 beats round-robin choice 1.
    applyStimulus(4'b0001, 1'b0);
    nextCycle();
    #1;
    checkOutput("t6 setup gnt", 32'(bus.gnt_o), 32'h1);
    nextCycle();
    applyStimulus(4'b0000, 1'b0);
    nextCycle();
    bus.urgent_i = 4'b0100;
    applyStimulus(4'b1111, 1'b0);
    #1;
    checkOutput("t6 idle gnt", 32'(bus.gnt_o), 32'h0);
    nextCycle();
    #1;
    checkOutput("t6 urgent gnt", 32'(bus.gnt_o), 32'h4);
`endif

    nextCycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
